// File: rtl/crc_engine.sv
// Table-driven reflected CRC engine. Accepts up to four little-endian bytes
// per request word and folds BPC bytes per cycle; the final CRC is held
// until the consumer accepts it.
module crc_engine #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF,
  parameter int unsigned BPC    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_bytes,
  input  logic        req_first,
  input  logic        req_last,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_crc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [31:0] data_q;
  logic [2:0]  bytes_q;
  logic [2:0]  ptr;
  logic        last_q;

  // One table entry: the byte index shifted through eight reflected steps.
  function automatic logic [31:0] table_entry(input int unsigned idx);
    logic [31:0] c;
    c = 32'(idx);
    for (int unsigned k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] crc_table [256];

  for (genvar g = 0; g < 256; g++) begin : g_table
    localparam logic [31:0] ENTRY = table_entry(g);
    assign crc_table[g] = ENTRY;
  end

  logic [2:0]  bytes_in;
  logic [31:0] crc_start;
  logic [31:0] crc_fold;
  logic [2:0]  idx;
  logic [7:0]  cur_byte;
  logic        run_end;

  assign bytes_in  = (req_bytes > 3'd4) ? 3'd4 : req_bytes;
  assign crc_start = req_first ? INIT : crc;
  assign run_end   = ({1'b0, ptr} + 4'(BPC)) >= {1'b0, bytes_q};

  // Reset gates req_ready so it reads 0 while rst is held low.
  assign req_ready = rst && (state == IDLE);
  assign busy      = (state != IDLE);

  // Fold up to BPC bytes starting at the pointer; bytes past the count are skipped.
  always_comb begin
    crc_fold = crc;
    idx      = ptr;
    cur_byte = '0;
    for (int unsigned k = 0; k < BPC; k++) begin
      idx      = ptr + 3'(k);
      cur_byte = data_q[{idx[1:0], 3'b000} +: 8];
      if (idx < bytes_q) begin
        crc_fold = crc_table[crc_fold[7:0] ^ cur_byte] ^ (crc_fold >> 8);
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      crc        <= INIT;
      data_q     <= '0;
      bytes_q    <= '0;
      ptr        <= '0;
      last_q     <= 1'b0;
      resp_valid <= 1'b0;
      resp_crc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            data_q  <= req_data;
            bytes_q <= bytes_in;
            last_q  <= req_last;
            ptr     <= '0;
            crc     <= crc_start;
            if (bytes_in != 3'd0) begin
              state <= RUN;
            end else if (req_last) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_crc   <= crc_start ^ XOROUT;
            end
          end
        end
        RUN: begin
          crc <= crc_fold;
          ptr <= ptr + 3'(BPC);
          if (run_end) begin
            if (last_q) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_crc   <= crc_fold ^ XOROUT;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: four instances (BPC 1/4/2 and a CRC-32C variant)
// driven from a vector table, with a per-instance queue of expected CRCs
// consumed when each instance completes a response handshake.
module tb_crc_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid  [4];
  logic        req_ready  [4];
  logic [31:0] req_data   [4];
  logic [2:0]  req_bytes  [4];
  logic        req_first  [4];
  logic        req_last   [4];
  logic        resp_valid [4];
  logic        resp_ready [4];
  logic [31:0] resp_crc   [4];
  logic        busy       [4];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [4][$];
  logic [31:0] popped;

  always #5 clk = ~clk;

  crc_engine u_bpc1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_data(req_data[0]), .req_bytes(req_bytes[0]), .req_first(req_first[0]),
    .req_last(req_last[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_crc(resp_crc[0]), .busy(busy[0]));

  crc_engine #(.BPC(4)) u_bpc4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_data(req_data[1]), .req_bytes(req_bytes[1]), .req_first(req_first[1]),
    .req_last(req_last[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_crc(resp_crc[1]), .busy(busy[1]));

  crc_engine #(.BPC(4), .POLY(32'h82F63B78)) u_crc32c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_data(req_data[2]), .req_bytes(req_bytes[2]), .req_first(req_first[2]),
    .req_last(req_last[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_crc(resp_crc[2]), .busy(busy[2]));

  crc_engine #(.BPC(2)) u_bpc2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_data(req_data[3]), .req_bytes(req_bytes[3]), .req_first(req_first[3]),
    .req_last(req_last[3]), .resp_valid(resp_valid[3]), .resp_ready(resp_ready[3]),
    .resp_crc(resp_crc[3]), .busy(busy[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Bit-serial reflected CRC over the low n bytes of w.
  function automatic logic [31:0] model_word(input logic [31:0] poly, input logic [31:0] c_in,
                                             input logic [31:0] w, input int n);
    logic [31:0] c;
    logic [31:0] sh;
    c = c_in;
    for (int b = 0; b < n; b++) begin
      sh = w >> (8 * b);
      c  = c ^ {24'h0, sh[7:0]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

  // Scoreboard: every completed response must match the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst && resp_valid[i] && resp_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_resp[%0d]: got crc %h, required no response", i, resp_crc[i]);
        end else begin
          popped = exp_q[i].pop_front();
          check($sformatf("resp_crc[%0d]", i), resp_crc[i], popped);
        end
      end
    end
  end

  task automatic send_word(input int i, input logic [31:0] d, input logic [2:0] b,
                           input bit f, input bit l, input int exp_run, input logic [31:0] exp_crc);
    int waited;
    int run;
    waited = 0;
    run    = 0;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_data[i]  = d;
    req_bytes[i] = b;
    req_first[i] = f;
    req_last[i]  = l;
    @(negedge clk);
    while (!req_ready[i] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("req_ready_wait[%0d]", i), 32'(req_ready[i]), 32'd1);
    if (l) exp_q[i].push_back(exp_crc);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    while (busy[i] && !resp_valid[i] && run < 20) begin
      run++;
      @(negedge clk);
    end
    check($sformatf("run_len[%0d] word %h", i, d), 32'(run), 32'(exp_run));
    if (l) begin
      check($sformatf("resp_valid[%0d]", i), 32'(resp_valid[i]), 32'd1);
      if (resp_ready[i]) begin
        @(negedge clk);
        check($sformatf("turnaround_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
      end
    end else begin
      check($sformatf("back_to_idle[%0d]", i), 32'(busy[i]), 32'd0);
    end
  endtask

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic [2:0]  bytes;
    bit          first;
    bit          last;
    int          run;
    logic [31:0] crc;
  } vec_t;

  vec_t vecs [22];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] crc_1234;
    crc_1234 = model_word(32'hEDB88320, 32'hFFFFFFFF, 32'h34333231, 4) ^ 32'hFFFFFFFF;

    vecs[0]  = '{0, 32'h34333231, 3'd4, 1'b1, 1'b0, 4, 32'h0};
    vecs[1]  = '{0, 32'h38373635, 3'd4, 1'b0, 1'b0, 4, 32'h0};
    vecs[2]  = '{0, 32'h00000039, 3'd1, 1'b0, 1'b1, 1, 32'hCBF43926};
    vecs[3]  = '{1, 32'h34333231, 3'd7, 1'b1, 1'b0, 1, 32'h0};
    vecs[4]  = '{1, 32'h38373635, 3'd5, 1'b0, 1'b0, 1, 32'h0};
    vecs[5]  = '{1, 32'h00000039, 3'd1, 1'b0, 1'b1, 1, 32'hCBF43926};
    vecs[6]  = '{2, 32'h34333231, 3'd4, 1'b1, 1'b0, 1, 32'h0};
    vecs[7]  = '{2, 32'h38373635, 3'd4, 1'b0, 1'b0, 1, 32'h0};
    vecs[8]  = '{2, 32'h00000039, 3'd1, 1'b0, 1'b1, 1, 32'hE3069283};
    vecs[9]  = '{3, 32'hAA333231, 3'd3, 1'b1, 1'b0, 2, 32'h0};
    vecs[10] = '{3, 32'hBB363534, 3'd3, 1'b0, 1'b0, 2, 32'h0};
    vecs[11] = '{3, 32'hCC393837, 3'd3, 1'b0, 1'b1, 2, 32'hCBF43926};
    vecs[12] = '{0, 32'h00000000, 3'd1, 1'b1, 1'b1, 1, 32'hD202EF8D};
    vecs[13] = '{0, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b1, 0, 32'h00000000};
    vecs[14] = '{0, 32'h34333231, 3'd6, 1'b1, 1'b0, 4, 32'h0};
    vecs[15] = '{0, 32'hDEADBEEF, 3'd0, 1'b0, 1'b0, 0, 32'h0};
    vecs[16] = '{0, 32'h38373635, 3'd4, 1'b0, 1'b0, 4, 32'h0};
    vecs[17] = '{0, 32'h00000039, 3'd1, 1'b0, 1'b1, 1, 32'hCBF43926};
    vecs[18] = '{0, 32'h34333231, 3'd4, 1'b1, 1'b1, 4, crc_1234};
    vecs[19] = '{0, 32'h38373635, 3'd4, 1'b0, 1'b0, 4, 32'h0};
    vecs[20] = '{0, 32'h00000039, 3'd1, 1'b0, 1'b1, 1, 32'hCBF43926};
    vecs[21] = '{0, 32'h00000000, 3'd0, 1'b0, 1'b1, 0, 32'hCBF43926};

    for (int i = 0; i < 4; i++) begin
      req_valid[i]  = 1'b0;
      req_data[i]   = '0;
      req_bytes[i]  = '0;
      req_first[i]  = 1'b0;
      req_last[i]   = 1'b0;
      resp_ready[i] = 1'b1;
    end

    // Reset state, then the first cycle after release.
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_req_ready[%0d]", i), 32'(req_ready[i]), 32'd0);
      check($sformatf("rst_resp_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
      check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_resp_crc[%0d]", i), resp_crc[i], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
    end

    for (int v = 0; v < 22; v++) begin
      send_word(vecs[v].inst, vecs[v].data, vecs[v].bytes, vecs[v].first,
                vecs[v].last, vecs[v].run, vecs[v].crc);
    end

    // Back-pressure: response held for 10 cycles, then released.
    resp_ready[0] = 1'b0;
    send_word(0, 32'h00000000, 3'd1, 1'b1, 1'b1, 1, 32'hD202EF8D);
    for (int c = 0; c < 10; c++) begin
      check("hold_resp_valid", 32'(resp_valid[0]), 32'd1);
      check("hold_resp_crc", resp_crc[0], 32'hD202EF8D);
      check("hold_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_req_ready", 32'(req_ready[0]), 32'd1);
    check("release_resp_valid", 32'(resp_valid[0]), 32'd0);

    // Reset in the middle of RUN on a complete message; no response may escape.
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_data[0]  = 32'h34333231;
    req_bytes[0] = 3'd4;
    req_first[0] = 1'b1;
    req_last[0]  = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun_busy", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_req_ready", 32'(req_ready[0]), 32'd0);
    check("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("abort_resp_crc", resp_crc[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("restart_ready", 32'(req_ready[0]), 32'd1);
    for (int v = 0; v < 3; v++) begin
      send_word(vecs[v].inst, vecs[v].data, vecs[v].bytes, vecs[v].first,
                vecs[v].last, vecs[v].run, vecs[v].crc);
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pending_resp[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 Parameter: POLY, default 32'hEDB88320, reflected (LSB-first) CRC-32 polynomial.
REQ-002 Parameter: INIT, default 32'hFFFFFFFF, CRC register value loaded at message start.
REQ-003 Parameter: XOROUT, default 32'hFFFFFFFF, value XORed into the register to form the result.
REQ-004 Parameter: BPC, default 1, bytes folded per cycle; legal values 1, 2 and 4.
REQ-005 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 Port: req_valid  input  1  request word present.
REQ-008 Port: req_ready  output  1  engine accepts a word this cycle.
REQ-009 Port: req_data  input  32  message bytes, little-endian; byte 0 is req_data[7:0] and is processed first.
REQ-010 Port: req_bytes  input  3  count of valid bytes in req_data, 0..4; values 5..7 are treated as 4.
REQ-011 Port: req_first  input  1  word starts a new message; the CRC register is loaded with INIT before this word's bytes.
REQ-012 Port: req_last  input  1  word ends the message; the result is produced after this word.
REQ-013 Port: resp_valid  output  1  resp_crc holds a final CRC.
REQ-014 Port: resp_ready  input  1  consumer accepts the response.
REQ-015 Port: resp_crc  output  32  final CRC, equal to the register value XOR XOROUT.
REQ-016 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The 256x32 lookup table SHALL be computed at elaboration from POLY by a constant function; no file loads.
REQ-018 Per-byte step: crc_next = table[crc[7:0] ^ b] ^ (crc >> 8).
REQ-019 FSM states SHALL be IDLE, RUN and DONE.
REQ-020 IDLE: req_ready=1; a handshake (req_valid & req_ready) latches data, bytes, first and last, and clears the byte pointer.
REQ-021 On the handshake, if req_first=1, crc is loaded with INIT in the same cycle.
REQ-022 On the handshake, if req_bytes=0, the state goes to DONE when req_last=1 and stays IDLE otherwise.
REQ-023 On the handshake, if req_bytes>0, the state goes to RUN.
REQ-024 RUN: each cycle folds min(BPC, remaining) bytes in order and advances the pointer; req_ready=0.
REQ-025 RUN occupies ceil(bytes/BPC) cycles; with BPC=1 and 4 bytes this is 4 cycles.
REQ-026 At the end of RUN, the state goes to DONE if the latched last=1, otherwise back to IDLE.
REQ-027 DONE: resp_valid=1 and resp_crc=crc^XOROUT; both are held stable until resp_ready=1.
REQ-028 In DONE, resp_valid & resp_ready SHALL return the state to IDLE; req_ready=0 throughout DONE.
REQ-029 Minimum turnaround: a new request is accepted the cycle after the response handshake.
REQ-030 Without req_first, crc carries over between messages, allowing CRC continuation.
REQ-031 req_first and req_last may both be set on one word; the word then forms a complete message.

Reset
REQ-032 While rst=0, the engine SHALL hold state=IDLE, crc=INIT, pointer=0, resp_valid=0, req_ready=0, busy=0, resp_crc=0.
REQ-033 Reset SHALL act immediately, aborting any RUN or DONE; a pending response is discarded.
REQ-034 The first cycle after rst deasserts, req_ready=1.

Verification
REQ-035 Defaults, BPC=1; words 0x34333231 (4 bytes, first), 0x38373635 (4 bytes), 0x00000039 (1 byte, last) -> resp_crc=0xCBF43926; RUN lasts 4+4+1 cycles.
REQ-036 Same stimulus with BPC=4 and with POLY=0x82F63B78 -> resp_crc 0xCBF43926 and 0xE3069283 respectively; RUN lasts 1 cycle per word.
REQ-037 Single word 0x00000000, 1 byte, first+last -> resp_crc=0xD202EF8D.
REQ-038 Single word with 0 bytes, first+last -> DONE the next cycle with resp_crc=0x00000000.
REQ-039 Hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_crc stable, req_ready=0; release -> IDLE next cycle.
REQ-040 Assert rst=0 mid-RUN, then restart the REQ-035 message -> no stale response, result 0xCBF43926.
